// File: rtl/uart_bus_master_if.sv
// Bundle of UART byte streams and memory-bus signals used by the UART bus master.
// The master modport is the bus-master side; slave is the environment side.
interface uart_bus_master_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;
   logic        busy;
   logic        err_pulse;

   modport master (
      input  rx_data, rx_valid, tx_ready, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
      output tx_data, tx_valid, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
             busy, err_pulse
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
      input  tx_data, tx_valid, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
             busy, err_pulse
   );
endinterface

// File: rtl/uart_bus_master.sv
// Debug/loader bus initiator: decodes 'R'/'W' byte commands from a UART receiver,
// performs one 32-bit word access on the shared memory bus, and replies over the UART.
module uart_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 2600000,
   parameter logic [7:0]  CMD_WRITE      = 8'h57,
   parameter logic [7:0]  CMD_READ       = 8'h52,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
   input logic                clk,
   input logic                resetn,
   uart_bus_master_if.master  bus
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle, StAddr, StData, StReq, StRd, StRdWait, StWr, StResp
   } state_e;

   state_e          state_q, state_d;
   logic            is_wr_q, is_wr_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     resp_q, resp_d;
   logic [2:0]      resp_cnt_q, resp_cnt_d;
   logic            fsm_err;
   logic            overrun;
   logic            granted;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         is_wr_q    <= 1'b0;
         byte_cnt_q <= '0;
         tmo_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_q     <= '0;
         resp_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_q      <= tmo_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         resp_cnt_q <= resp_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      byte_cnt_d = byte_cnt_q;
      tmo_d      = tmo_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      resp_d     = resp_q;
      resp_cnt_d = resp_cnt_q;
      fsm_err    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == CMD_READ || bus.rx_data == CMD_WRITE) begin
                  is_wr_d    = (bus.rx_data == CMD_WRITE);
                  byte_cnt_d = '0;
                  tmo_d      = '0;
                  state_d    = StAddr;
               end else begin
                  fsm_err = 1'b1;
               end
            end
         end
         StAddr, StData: begin
            // A byte arriving in the expiry cycle still counts and restarts the timer.
            if (bus.rx_valid) begin
               tmo_d      = '0;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (state_q == StAddr) begin
                  addr_d = {addr_q[23:0], bus.rx_data};
               end else begin
                  wdata_d = {wdata_q[23:0], bus.rx_data};
               end
               if (byte_cnt_q == 2'd3) begin
                  state_d = (state_q == StAddr && is_wr_q) ? StData : StReq;
               end
            end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
               fsm_err = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StReq: begin
            if (bus.bus_gnt) begin
               state_d = is_wr_q ? StWr : StRd;
            end
         end
         StRd: begin
            state_d = StRdWait;
         end
         StRdWait: begin
            if (!bus.mem_rbusy) begin
               resp_d     = bus.mem_rdata;
               resp_cnt_d = 3'd4;
               state_d    = StResp;
            end
         end
         StWr: begin
            if (!bus.mem_wbusy) begin
               resp_d     = {ACK_BYTE, 24'h0};
               resp_cnt_d = 3'd1;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (bus.tx_ready) begin
               resp_d     = {resp_q[23:0], 8'h00};
               resp_cnt_d = resp_cnt_q - 3'd1;
               if (resp_cnt_q == 3'd1) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bytes arriving while a bus access or reply is in flight are dropped.
   assign overrun = bus.rx_valid &&
                    (state_q inside {StReq, StRd, StRdWait, StWr, StResp});

   assign bus.err_pulse = fsm_err | overrun;
   assign bus.busy      = (state_q != StIdle);
   assign bus.bus_req   = (state_q inside {StReq, StRd, StRdWait, StWr});
   assign granted       = bus.bus_req & bus.bus_gnt;

   // Bus outputs stay quiet unless the arbiter has handed us the bus.
   assign bus.mem_addr  = granted ? {addr_q[31:2], 2'b00} : 32'h0;
   assign bus.mem_wdata = granted ? wdata_q : 32'h0;
   assign bus.mem_rstrb = granted && (state_q == StRd);
   assign bus.mem_wmask = (granted && state_q == StWr) ? 4'hF : 4'h0;

   assign bus.tx_valid  = (state_q == StResp);
   assign bus.tx_data   = resp_q[31:24];

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master: write, read with wait states,
// grant delay, inter-byte timeout, unknown/overrun bytes and async reset mid-write.
module tb_uart_bus_master;

   logic clk;
   logic resetn;
   int   n_cmp;
   int   n_err;

   uart_bus_master_if bus ();

   uart_bus_master #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_err, input string tag);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      #1;
      check(tag, 32'(bus.err_pulse), 32'(exp_err));
      cyc();
      bus.rx_valid = 1'b0;
      #1;
   endtask

   task automatic drain(input logic [31:0] word, input string tag);
      logic [31:0] w;
      w = word;
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check(tag, 32'(bus.tx_data), 32'(w[31:24]));
         w = {w[23:0], 8'h00};
         cyc();
      end
      bus.tx_ready = 1'b0;
      #1;
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_word;
      n_cmp         = 0;
      n_err         = 0;
      resetn        = 1'b0;
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.tx_ready  = 1'b0;
      bus.bus_gnt   = 1'b0;
      bus.mem_rdata = 32'h0;
      bus.mem_rbusy = 1'b0;
      bus.mem_wbusy = 1'b0;
      #2;
      check("rst_busy",  32'(bus.busy),      32'd0);
      check("rst_req",   32'(bus.bus_req),   32'd0);
      check("rst_txv",   32'(bus.tx_valid),  32'd0);
      check("rst_txd",   32'(bus.tx_data),   32'd0);
      check("rst_addr",  bus.mem_addr,       32'd0);
      check("rst_wdata", bus.mem_wdata,      32'd0);
      check("rst_wmask", 32'(bus.mem_wmask), 32'd0);
      check("rst_rstrb", 32'(bus.mem_rstrb), 32'd0);
      check("rst_err",   32'(bus.err_pulse), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cyc();

      // Write 0xDEADBEEF to 0x10 with zero-wait memory.
      bus.bus_gnt = 1'b1;
      send_byte(8'h57, 1'b0, "wr_cmd");
      check("wr_busy", 32'(bus.busy), 32'd1);
      send_byte(8'h00, 1'b0, "wr_a0");
      send_byte(8'h00, 1'b0, "wr_a1");
      send_byte(8'h00, 1'b0, "wr_a2");
      send_byte(8'h10, 1'b0, "wr_a3");
      send_byte(8'hDE, 1'b0, "wr_d0");
      send_byte(8'hAD, 1'b0, "wr_d1");
      send_byte(8'hBE, 1'b0, "wr_d2");
      send_byte(8'hEF, 1'b0, "wr_d3");
      check("wr_req",       32'(bus.bus_req),   32'd1);
      check("wr_req_wmask", 32'(bus.mem_wmask), 32'd0);
      cyc();
      check("wr_wmask", 32'(bus.mem_wmask), 32'hF);
      check("wr_addr",  bus.mem_addr,       32'h0000_0010);
      check("wr_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
      cyc();
      check("wr_wmask_drop", 32'(bus.mem_wmask), 32'd0);
      check("wr_req_drop",   32'(bus.bus_req),   32'd0);
      check("wr_txv",        32'(bus.tx_valid),  32'd1);
      check("wr_ack",        32'(bus.tx_data),   32'h4B);
      bus.tx_ready = 1'b1;
      cyc();
      bus.tx_ready = 1'b0;
      #1;
      check("wr_txv_done", 32'(bus.tx_valid), 32'd0);
      check("wr_idle",     32'(bus.busy),     32'd0);

      // Read from 0x00420004 with three busy cycles; slow transmitter plus an overrun byte.
      send_byte(8'h52, 1'b0, "rd_cmd");
      send_byte(8'h00, 1'b0, "rd_a0");
      send_byte(8'h42, 1'b0, "rd_a1");
      send_byte(8'h00, 1'b0, "rd_a2");
      send_byte(8'h04, 1'b0, "rd_a3");
      check("rd_req",       32'(bus.bus_req),   32'd1);
      check("rd_req_rstrb", 32'(bus.mem_rstrb), 32'd0);
      cyc();
      check("rd_rstrb", 32'(bus.mem_rstrb), 32'd1);
      check("rd_addr",  bus.mem_addr,       32'h0042_0004);
      cyc();
      bus.mem_rbusy = 1'b1;
      bus.mem_rdata = 32'hDEAD_DEAD;
      check("rd_rstrb_once", 32'(bus.mem_rstrb), 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rd_wait_txv", 32'(bus.tx_valid), 32'd0);
         check("rd_wait_req", 32'(bus.bus_req),  32'd1);
         cyc();
      end
      bus.mem_rbusy = 1'b0;
      bus.mem_rdata = 32'h1234_5678;
      cyc();
      bus.mem_rdata = 32'h0;
      exp_word = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (i == 0 && k == 1) begin
               bus.rx_data  = 8'h99;
               bus.rx_valid = 1'b1;
            end
            #1;
            check("rd_hold_txv", 32'(bus.tx_valid), 32'd1);
            check("rd_hold_txd", 32'(bus.tx_data),  32'(exp_word[31:24]));
            if (i == 0 && k == 1) begin
               check("ovr_err", 32'(bus.err_pulse), 32'd1);
            end
            cyc();
            bus.rx_valid = 1'b0;
         end
         bus.tx_ready = 1'b1;
         #1;
         check("rd_accept_txd", 32'(bus.tx_data), 32'(exp_word[31:24]));
         exp_word = {exp_word[23:0], 8'h00};
         cyc();
         bus.tx_ready = 1'b0;
      end
      #1;
      check("rd_txv_done", 32'(bus.tx_valid), 32'd0);
      check("rd_idle",     32'(bus.busy),     32'd0);

      // Grant delayed 10 cycles; unaligned address 0x103 is forced to 0x100.
      bus.bus_gnt = 1'b0;
      send_byte(8'h52, 1'b0, "gd_cmd");
      send_byte(8'h00, 1'b0, "gd_a0");
      send_byte(8'h00, 1'b0, "gd_a1");
      send_byte(8'h01, 1'b0, "gd_a2");
      send_byte(8'h03, 1'b0, "gd_a3");
      for (int i = 0; i < 10; i++) begin
         check("gd_req",   32'(bus.bus_req),   32'd1);
         check("gd_rstrb", 32'(bus.mem_rstrb), 32'd0);
         check("gd_wmask", 32'(bus.mem_wmask), 32'd0);
         check("gd_addr",  bus.mem_addr,       32'd0);
         cyc();
      end
      bus.bus_gnt = 1'b1;
      #1;
      check("gd_gnt_rstrb", 32'(bus.mem_rstrb), 32'd0);
      cyc();
      check("gd_rstrb", 32'(bus.mem_rstrb), 32'd1);
      check("gd_addr_al", bus.mem_addr,     32'h0000_0100);
      bus.mem_rdata = 32'hA5A5_5A5A;
      cyc();
      cyc();
      bus.mem_rdata = 32'h0;
      drain(32'hA5A5_5A5A, "gd_tx");

      // Timeout after 'W' and two address bytes, then a fresh read.
      send_byte(8'h57, 1'b0, "to_cmd");
      send_byte(8'h00, 1'b0, "to_a0");
      send_byte(8'h00, 1'b0, "to_a1");
      for (int i = 1; i < 100; i++) begin
         cyc();
      end
      check("to_early", 32'(bus.err_pulse), 32'd0);
      cyc();
      check("to_err",      32'(bus.err_pulse), 32'd1);
      check("to_err_busy", 32'(bus.busy),      32'd1);
      cyc();
      check("to_idle",     32'(bus.busy),      32'd0);
      check("to_err_once", 32'(bus.err_pulse), 32'd0);
      send_byte(8'h52, 1'b0, "to_rd_cmd");
      check("to_rd_busy", 32'(bus.busy), 32'd1);
      send_byte(8'h00, 1'b0, "to_rd_a0");
      send_byte(8'h00, 1'b0, "to_rd_a1");
      send_byte(8'h00, 1'b0, "to_rd_a2");
      send_byte(8'h08, 1'b0, "to_rd_a3");
      check("to_rd_req", 32'(bus.bus_req), 32'd1);
      cyc();
      check("to_rd_rstrb", 32'(bus.mem_rstrb), 32'd1);
      check("to_rd_addr",  bus.mem_addr,       32'h0000_0008);
      bus.mem_rdata = 32'hCAFE_F00D;
      cyc();
      cyc();
      bus.mem_rdata = 32'h0;
      drain(32'hCAFE_F00D, "to_rd_tx");

      // Unknown command byte in IDLE.
      send_byte(8'h41, 1'b1, "unk_err");
      check("unk_idle", 32'(bus.busy), 32'd0);

      // Async reset during a stalled write.
      bus.mem_wbusy = 1'b1;
      send_byte(8'h57, 1'b0, "ar_cmd");
      send_byte(8'h00, 1'b0, "ar_a0");
      send_byte(8'h00, 1'b0, "ar_a1");
      send_byte(8'h00, 1'b0, "ar_a2");
      send_byte(8'h20, 1'b0, "ar_a3");
      send_byte(8'h01, 1'b0, "ar_d0");
      send_byte(8'h02, 1'b0, "ar_d1");
      send_byte(8'h03, 1'b0, "ar_d2");
      send_byte(8'h04, 1'b0, "ar_d3");
      cyc();
      check("ar_wmask",  32'(bus.mem_wmask), 32'hF);
      check("ar_wdata",  bus.mem_wdata,      32'h0102_0304);
      cyc();
      check("ar_wmask_hold", 32'(bus.mem_wmask), 32'hF);
      #2;
      resetn = 1'b0;
      #1;
      check("ar_wmask_rst", 32'(bus.mem_wmask), 32'd0);
      check("ar_req_rst",   32'(bus.bus_req),   32'd0);
      check("ar_busy_rst",  32'(bus.busy),      32'd0);
      bus.mem_wbusy = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      cyc();
      send_byte(8'h52, 1'b0, "ar_new_cmd");
      check("ar_new_busy", 32'(bus.busy), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
